func_sweep: RTL

FUNC_SWEEP -- requirements
Module: func_sweep

---
 rtl/func_sweep.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/func_sweep.sv
// Exhaustive truth-table sweep of an N-input combinational function: drives every
// input vector, waits SETTLE cycles, samples f_in against EXP and tallies mismatches.
module func_sweep #(
    parameter int                  N      = 3,
    parameter logic [(1<<N)-1:0]   EXP    = 8'b1001_0110,
    parameter int                  SETTLE = 1,
    parameter bit                  GRAY   = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic         i_f_in,
    output logic [N-1:0] o_stim,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_pass,
    output logic [N:0]   o_err_count,
    output logic [N-1:0] o_first_err_vec
);

    // state      | meaning
    // S_IDLE     | waiting for start, results held
    // S_SETTLE   | vector applied, counting down settle cycles
    // S_SAMPLE   | compare f_in with EXP[stim], advance to next vector
    // S_DONE     | one-cycle done pulse, pass valid
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    localparam int          NV       = 1 << N;
    localparam logic [3:0]  CNT_LOAD = 4'(SETTLE - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_idx;
    logic [N-1:0]   r_stim;
    logic [N-1:0]   r_first;
    logic [N:0]     r_err;
    logic [3:0]     r_cnt;
    logic           r_pass;
    logic [N-1:0]   w_idx_inc;
    logic           w_last;
    logic           w_mismatch;

    function automatic logic [N-1:0] vec(input logic [N-1:0] i);
        return GRAY ? (i ^ (i >> 1)) : i;
    endfunction

    assign w_idx_inc  = r_idx + N'(1);
    assign w_last     = &r_idx;
    assign w_mismatch = (i_f_in != EXP[r_stim]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (i_abort)           w_state_nxt = S_IDLE;
                else if (r_cnt == '0)  w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (i_abort)      w_state_nxt = S_IDLE;
                else if (w_last)  w_state_nxt = S_DONE;
                else              w_state_nxt = S_SETTLE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_SETTLE, S_SAMPLE: o_busy = 1'b1;
            S_DONE:             o_done = 1'b1;
            default: ;
        endcase
    end

    // Abort takes priority over the sample in progress, so an aborted SAMPLE is not counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx   <= '0;
            r_stim  <= '0;
            r_first <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_idx   <= '0;
                        r_stim  <= vec('0);
                        r_cnt   <= CNT_LOAD;
                        r_err   <= '0;
                        r_first <= '0;
                        r_pass  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (i_abort) begin
                        r_stim <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (i_abort) begin
                        r_stim <= '0;
                    end else begin
                        if (w_mismatch) begin
                            if (r_err != (N+1)'(NV)) r_err <= r_err + (N+1)'(1);
                            if (r_err == '0)         r_first <= r_stim;
                        end
                        if (w_last) begin
                            r_pass <= (r_err == '0) && !w_mismatch;
                        end else begin
                            r_idx  <= w_idx_inc;
                            r_stim <= vec(w_idx_inc);
                            r_cnt  <= CNT_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_stim <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_stim          = r_stim;
    assign o_pass          = r_pass;
    assign o_err_count     = r_err;
    assign o_first_err_vec = r_first;

endmodule
